pmem_line_adaptor: RTL and testbench
====================================

PMEM_LINE_ADAPTOR -- requirements
Module: pmem_line_adaptor

Interface
REQ-001 Parameter: none; all widths are fixed (line 256 bits, beat 64 bits, 4 beats per line).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 address_i  input  32  line request address from the L2 cache (pmem_address side).
REQ-005 read_i  input  1  line read request; held high by the requester until resp_o.
REQ-006 write_i  input  1  line write-back request; held high by the requester until resp_o.
REQ-007 line_i  input  256  write-back line data; stable while write_i is high.
REQ-008 line_o  output  256  assembled read line (pmem_rdata side).
REQ-009 resp_o  output  1  one-cycle completion pulse for the current line request.
REQ-010 burst_i  input  64  read beat from memory.
REQ-011 burst_o  output  64  write beat to memory.
REQ-012 address_o  output  32  line-aligned memory address.
REQ-013 read_o  output  1  memory burst read request.
REQ-014 write_o  output  1  memory burst write request.
REQ-015 resp_i  input  1  memory beat strobe; each high cycle transfers one 64-bit beat.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, READ, WRITE, DONE.
REQ-017 In IDLE, write_i high SHALL latch address_i and line_i and move to WRITE; otherwise read_i high SHALL latch address_i and move to READ (write has priority when both are high).
REQ-018 address_o SHALL equal {latched_address[31:5], 5'b0} in READ and WRITE, and 0 otherwise.
REQ-019 read_o SHALL be high exactly in READ, and write_o exactly in WRITE; both are decoded from registered state only.
REQ-020 A 2-bit beat counter SHALL reset to 0 on entry to READ/WRITE and increment on each resp_i-high cycle in READ/WRITE.
REQ-021 In READ with resp_i high, burst_i SHALL be stored into line bits [64*k+63 : 64*k], where k is the counter value (beat 0 = bits 63:0).
REQ-022 In WRITE, burst_o SHALL present latched line bits [64*k+63 : 64*k]; at all other times burst_o SHALL be 0.
REQ-023 resp_i low in READ/WRITE SHALL hold the counter and data (gaps between beats are legal).
REQ-024 The cycle that accepts beat 3 SHALL transition to DONE, and the counter SHALL wrap to 0.
REQ-025 DONE SHALL last one cycle with resp_o=1, then go to IDLE; resp_o SHALL be 0 in every other state.
REQ-026 line_o SHALL show the assembled read buffer continuously and SHALL hold the last completed read line until the next read overwrites it; line_o is not valid for a write.
REQ-027 resp_i SHALL be ignored in IDLE and DONE.
REQ-028 read_i and write_i SHALL be ignored outside IDLE; the requester deasserts on the cycle after resp_o, so DONE->IDLE SHALL NOT start a duplicate request.
REQ-029 Latency: request sampled at cycle 0 -> read_o/write_o at cycle 1. With beats at cycles 1-4, resp_o is at cycle 5 (minimum 5 cycles from request to resp_o).

Reset
REQ-030 On rst: state SHALL go to IDLE, the counter to 0, the address latch to 0, the line buffer to 0, and the write-data latch to 0.
REQ-031 After reset, all outputs SHALL be 0: read_o, write_o, resp_o, address_o, burst_o, line_o.
REQ-032 rst asserted mid-burst SHALL abort the transfer the next edge without a resp_o pulse; partial data is discarded.

Verification
REQ-033 Read, back-to-back beats: address_i=0x0000_1234, read_i=1; burst_i=0x...11, 22, 33, 44 with resp_i at cycles 1-4. Required: address_o=0x0000_1220 at cycles 1-4, resp_o only at cycle 5, line_o={44,33,22,11}.
REQ-034 Write with gaps: line_i={D3,D2,D1,D0}, write_i=1; resp_i pattern 1,0,0,1,1,0,1. Required: burst_o goes D0, D1, D1, D1, D2, D3, D3; write_o drops after the 4th beat; there is one resp_o pulse.
REQ-035 Read and write requested together: read_i=write_i=1 in IDLE. Required: WRITE is entered, write_o=1, read_o stays 0.
REQ-036 Stray strobe: resp_i=1 while IDLE for 3 cycles, then a read. Required: the counter starts at 0 and beat 0 lands in bits 63:0.
REQ-037 Reset mid-read: rst after 2 beats. Required: IDLE, all outputs 0, and no resp_o. A following read completes normally with a fresh counter.
REQ-038 Consecutive requests: a read completes, then write_i asserts the cycle after resp_o. Required: the write starts from IDLE, and line_o retains the prior read line throughout the write.

Source files
------------

// File: rtl/pmem_line_adaptor_if.sv
// Bundles the cache-side line request and memory-side beat signals of the adaptor.
// The slave modport is the adaptor's view; the master modport is the environment's view.
interface pmem_line_adaptor_if;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/pmem_line_adaptor.sv
// Converts 256-bit line read/write-back requests into four 64-bit memory beats.
// Beat k always maps to line bits [64*k+63 : 64*k].
module pmem_line_adaptor (
  input  logic                 clk,
  input  logic                 rst,
  pmem_line_adaptor_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   line_q, line_d;
  logic [255:0]   wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.write_i) begin
          addr_d  = bus.address_i;
          wdata_d = bus.line_i;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (bus.read_i) begin
          addr_d  = bus.address_i;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          line_d[{cnt_q, 6'd0} +: 64] = bus.burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All memory-side outputs decode from registered state only.
  always_comb begin
    bus.read_o    = (state_q == READ);
    bus.write_o   = (state_q == WRITE);
    bus.resp_o    = (state_q == DONE);
    bus.line_o    = line_q;
    bus.address_o = '0;
    bus.burst_o   = '0;
    if (state_q == READ || state_q == WRITE)
      bus.address_o = addr_q & 32'hFFFF_FFE0;
    if (state_q == WRITE)
      bus.burst_o = wdata_q[{cnt_q, 6'd0} +: 64];
  end

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Directed bench for pmem_line_adaptor: reads, gapped write-back, priority, stray strobes, reset abort.
module tb_pmem_line_adaptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests  = 0;
  int unsigned failed = 0;

  pmem_line_adaptor_if bus ();

  pmem_line_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".read_o"},    256'(bus.read_o),    256'(0));
    chk({tag, ".write_o"},   256'(bus.write_o),   256'(0));
    chk({tag, ".resp_o"},    256'(bus.resp_o),    256'(0));
    chk({tag, ".address_o"}, 256'(bus.address_o), 256'(0));
    chk({tag, ".burst_o"},   256'(bus.burst_o),   256'(0));
  endtask

  localparam logic [63:0] B11 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B22 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B33 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B44 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0  = 64'hD0D0_0000_0000_00D0;
  localparam logic [63:0] D1  = 64'hD1D1_0000_0000_00D1;
  localparam logic [63:0] D2  = 64'hD2D2_0000_0000_00D2;
  localparam logic [63:0] D3  = 64'hD3D3_0000_0000_00D3;

  logic [255:0] read_line;
  logic [63:0]  rbeats [4];
  logic [63:0]  wexp   [7];
  logic         wpat   [7];

  initial begin
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    read_line     = {B44, B33, B22, B11};

    // Reset state
    tick; tick;
    rst = 1'b0;
    chk_idle_zero("reset");
    chk("reset.line_o", bus.line_o, 256'(0));

    // Read with back-to-back beats
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    tick;
    rbeats = '{B11, B22, B33, B44};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd.read_o[%0d]", i),    256'(bus.read_o),    256'(1));
      chk($sformatf("rd.address_o[%0d]", i), 256'(bus.address_o), 256'(32'h0000_1220));
      chk($sformatf("rd.resp_o[%0d]", i),    256'(bus.resp_o),    256'(0));
      chk($sformatf("rd.burst_o[%0d]", i),   256'(bus.burst_o),   256'(0));
      bus.burst_i = rbeats[i];
      bus.resp_i  = 1'b1;
      tick;
    end
    chk("rd.resp_o_done",    256'(bus.resp_o),    256'(1));
    chk("rd.read_o_done",    256'(bus.read_o),    256'(0));
    chk("rd.address_o_done", 256'(bus.address_o), 256'(0));
    chk("rd.line_o",         bus.line_o,          read_line);

    // Write-back requested the cycle after resp_o
    bus.read_i  = 1'b0;
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.write_i = 1'b1;
    bus.address_i = 32'h8000_0047;
    bus.line_i  = {D3, D2, D1, D0};
    tick;
    chk_idle_zero("wr.idle");
    chk("wr.idle.line_o", bus.line_o, read_line);
    tick;
    wexp = '{D0, D1, D1, D1, D2, D3, D3};
    wpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("wr.write_o[%0d]", i),   256'(bus.write_o),   256'(1));
      chk($sformatf("wr.burst_o[%0d]", i),   256'(bus.burst_o),   256'(wexp[i]));
      chk($sformatf("wr.address_o[%0d]", i), 256'(bus.address_o), 256'(32'h8000_0040));
      chk($sformatf("wr.resp_o[%0d]", i),    256'(bus.resp_o),    256'(0));
      chk($sformatf("wr.line_o[%0d]", i),    bus.line_o,          read_line);
      bus.resp_i = wpat[i];
      tick;
    end
    chk("wr.resp_o_done",  256'(bus.resp_o),  256'(1));
    chk("wr.write_o_done", 256'(bus.write_o), 256'(0));
    chk("wr.burst_o_done", 256'(bus.burst_o), 256'(0));
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
    tick;
    chk_idle_zero("wr.after");
    chk("wr.after.line_o", bus.line_o, read_line);

    // Read and write together: write wins
    bus.read_i  = 1'b1;
    bus.write_i = 1'b1;
    bus.address_i = 32'h0000_0100;
    bus.line_i  = {D0, D1, D2, D3};
    tick;
    chk("both.write_o", 256'(bus.write_o), 256'(1));
    chk("both.read_o",  256'(bus.read_o),  256'(0));
    chk("both.burst_o", 256'(bus.burst_o), 256'(D3));
    bus.resp_i = 1'b1;
    tick; tick; tick;
    chk("both.read_o_mid", 256'(bus.read_o), 256'(0));
    tick;
    chk("both.resp_o", 256'(bus.resp_o), 256'(1));
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b0;
    tick;
    chk_idle_zero("both.after");
    chk("both.line_o", bus.line_o, read_line);

    // Stray strobes in IDLE, then a read
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("stray.read_o[%0d]", i), 256'(bus.read_o), 256'(0));
      chk($sformatf("stray.resp_o[%0d]", i), 256'(bus.resp_o), 256'(0));
      chk($sformatf("stray.line_o[%0d]", i), bus.line_o,       read_line);
    end
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_ABCD;
    tick;
    chk("stray.read_o",    256'(bus.read_o),    256'(1));
    chk("stray.address_o", 256'(bus.address_o), 256'(32'h0000_ABC0));
    bus.burst_i = 64'hA0A0_A0A0_A0A0_A0A0;
    tick;
    chk("stray.beat0", 256'(bus.line_o[63:0]), 256'(64'hA0A0_A0A0_A0A0_A0A0));
    chk("stray.upper", 256'(bus.line_o[255:64]), 256'(read_line[255:64]));
    bus.burst_i = 64'hA1A1_A1A1_A1A1_A1A1; tick;
    bus.burst_i = 64'hA2A2_A2A2_A2A2_A2A2; tick;
    bus.burst_i = 64'hA3A3_A3A3_A3A3_A3A3; tick;
    chk("stray.resp_o_done", 256'(bus.resp_o), 256'(1));
    chk("stray.line_o", bus.line_o,
        {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
         64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0});
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    tick;

    // Reset after two beats of a read
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0200;
    tick;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h5555_5555_5555_5555; tick;
    chk("rst.resp_o_b0", 256'(bus.resp_o), 256'(0));
    bus.burst_i = 64'h6666_6666_6666_6666; tick;
    chk("rst.resp_o_b1", 256'(bus.resp_o), 256'(0));
    chk("rst.read_o_b1", 256'(bus.read_o), 256'(1));
    rst = 1'b1;
    bus.read_i = 1'b0;
    tick;
    chk_idle_zero("rst.abort");
    chk("rst.abort.line_o", bus.line_o, 256'(0));
    rst = 1'b0;
    bus.resp_i = 1'b0;
    tick;
    chk("rst.abort.resp_o_after", 256'(bus.resp_o), 256'(0));
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0300;
    tick;
    chk("rst.reread.address_o", 256'(bus.address_o), 256'(32'h0000_0300));
    bus.resp_i = 1'b1;
    bus.burst_i = 64'h0000_0000_0000_0C00; tick;
    bus.burst_i = 64'h0000_0000_0000_0C01; tick;
    bus.burst_i = 64'h0000_0000_0000_0C02; tick;
    chk("rst.reread.resp_o_mid", 256'(bus.resp_o), 256'(0));
    bus.burst_i = 64'h0000_0000_0000_0C03; tick;
    chk("rst.reread.resp_o", 256'(bus.resp_o), 256'(1));
    chk("rst.reread.line_o", bus.line_o,
        {64'h0000_0000_0000_0C03, 64'h0000_0000_0000_0C02,
         64'h0000_0000_0000_0C01, 64'h0000_0000_0000_0C00});
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    tick;
    chk_idle_zero("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
